// File: rtl/alu_hs_if.sv
// alu_hs_if: operand/result handshake bundle for alu_hs.
// The master side is the sequencer, which drives operands and consumes results.
// The slave side is the ALU itself.
interface alu_hs_if #(
  parameter int data_width = 32
);
  logic [data_width-1:0] A;
  logic [data_width-1:0] B;
  logic [3:0]            op;
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] R;
  logic [3:0]            flags;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output A, B, op, in_valid, out_ready,
    input  in_ready, R, flags, out_valid
  );

  modport slave (
    input  A, B, op, in_valid, out_ready,
    output in_ready, R, flags, out_valid
  );
endinterface

// File: rtl/alu_hs.sv
// alu_hs: handshaked ALU with {N,Z,C,V} flags.
// Single-cycle operations finish on the accept edge.
// Variable shifts run one bit per cycle.
// Macro ALU_MUL_EN: when defined, opcode f is an iterative shift-add multiply.
// When it is undefined, opcode f returns zero and no multiplier is built.
module alu_hs #(
  parameter  int data_width = 32,
  localparam int sh_width   = $clog2(data_width)
) (
  input logic     clk,
  input logic     rst,
  alu_hs_if.slave bus
);

  localparam int msb      = data_width - 1;
  localparam int cntWidth = sh_width + 1;

  localparam logic [3:0] OP_SUB  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_NAND = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_NOR  = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_NOTA = 4'h7;
  localparam logic [3:0] OP_NOTB = 4'h8;
  localparam logic [3:0] OP_INCB = 4'h9;
  localparam logic [3:0] OP_INCA = 4'ha;
  localparam logic [3:0] OP_DECA = 4'hb;
  localparam logic [3:0] OP_DECB = 4'hc;
  localparam logic [3:0] OP_SHL  = 4'hd;
  localparam logic [3:0] OP_SHR  = 4'he;
  localparam logic [3:0] OP_MUL  = 4'hf;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [data_width-1:0] result_q, result_d;
  logic [3:0]            flags_q, flags_d;
  logic [data_width-1:0] work_q, work_d;
  logic                  carry_q, carry_d;
  logic [cntWidth-1:0]   count_q, count_d;
  logic [3:0]            opSel_q, opSel_d;

  logic [data_width-1:0] addX, addY;
  logic                  addSub;
  logic [data_width:0]   addFull;
  logic                  addOvf;
  logic [data_width-1:0] aluRes;
  logic                  aluC, aluV;
  logic [3:0]            aluFlags;

  logic                  startShift;
  logic [sh_width-1:0]   shAmt;
  logic                  startMul;
  logic                  mulActive;
  logic [data_width-1:0] mulLoNext;
  logic                  mulHiNonZero;

  assign startShift = (bus.op == OP_SHL) || (bus.op == OP_SHR);
  assign shAmt      = bus.B[sh_width-1:0];

  // Route the operands of every add/subtract style opcode through one shared adder.
  always_comb begin
    addX   = bus.A;
    addY   = '0;
    addSub = 1'b0;
    case (bus.op)
      OP_SUB: begin
        addY   = bus.B;
        addSub = 1'b1;
      end
      OP_ADD: begin
        addY = bus.B;
      end
      OP_INCB: begin
        addX = bus.B;
        addY = data_width'(1);
      end
      OP_INCA: begin
        addY = data_width'(1);
      end
      OP_DECA: begin
        addY   = data_width'(1);
        addSub = 1'b1;
      end
      OP_DECB: begin
        addX   = bus.B;
        addY   = data_width'(1);
        addSub = 1'b1;
      end
      default: begin
        addY = '0;
      end
    endcase
  end

  // The extra top bit is the carry for adds and the borrow for subtracts.
  assign addFull = addSub ? ({1'b0, addX} - {1'b0, addY})
                          : ({1'b0, addX} + {1'b0, addY});

  // Signed overflow occurs when the result sign disagrees with what the operand signs allow.
  assign addOvf = addSub ? ((addX[msb] != addY[msb]) && (addFull[msb] != addX[msb]))
                         : ((addX[msb] == addY[msb]) && (addFull[msb] != addX[msb]));

  // Compute the single-cycle result and its carry/overflow.
  // Shift and opcode f results come from the iterative path instead.
  always_comb begin
    aluRes = '0;
    aluC   = 1'b0;
    aluV   = 1'b0;
    case (bus.op)
      OP_SUB, OP_ADD, OP_INCB, OP_INCA, OP_DECA, OP_DECB: begin
        aluRes = addFull[msb:0];
        aluC   = addFull[data_width];
        aluV   = addOvf;
      end
      OP_NAND: aluRes = ~(bus.A & bus.B);
      OP_AND:  aluRes = bus.A & bus.B;
      OP_OR:   aluRes = bus.A | bus.B;
      OP_NOR:  aluRes = ~(bus.A | bus.B);
      OP_XOR:  aluRes = bus.A ^ bus.B;
      OP_NOTA: aluRes = ~bus.A;
      OP_NOTB: aluRes = ~bus.B;
      default: aluRes = '0;
    endcase
  end

  assign aluFlags = {aluRes[msb], (aluRes == '0), aluC, aluV};

`ifdef ALU_MUL_EN
  logic [data_width-1:0] mcand_q;
  logic [data_width-1:0] prodHi_q, prodHi_d;
  logic [data_width:0]   mulSum;
  logic                  accept;

  assign accept    = (state_q == IDLE) && bus.in_valid;
  assign startMul  = (bus.op == OP_MUL);
  assign mulActive = (opSel_q == OP_MUL);

  // The product is held as {prodHi_q, work_q}, with the multiplier in the low half.
  // Each step conditionally adds the multiplicand into the high half.
  // The whole product then shifts right by one bit.
  assign mulSum       = {1'b0, prodHi_q} + (work_q[0] ? {1'b0, mcand_q} : '0);
  assign prodHi_d     = mulSum[data_width:1];
  assign mulLoNext    = {mulSum[0], work_q[msb:1]};
  assign mulHiNonZero = |prodHi_d;

  // Hold the multiplicand and accumulate the upper half of the product while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      prodHi_q <= '0;
    end else if (accept && startMul) begin
      mcand_q  <= bus.A;
      prodHi_q <= '0;
    end else if ((state_q == BUSY) && mulActive) begin
      prodHi_q <= prodHi_d;
    end
  end
`else
  assign startMul     = 1'b0;
  assign mulActive    = 1'b0;
  assign mulLoNext    = '0;
  assign mulHiNonZero = 1'b0;
`endif

  // Next-state logic for the accept / iterate / present-result sequence.
  // Results are captured only on the edge that enters DONE.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    flags_d  = flags_q;
    work_d   = work_q;
    carry_d  = carry_q;
    count_d  = count_q;
    opSel_d  = opSel_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          opSel_d = bus.op;
          work_d  = bus.A;
          carry_d = 1'b0;
          if (startShift) begin
            count_d = {1'b0, shAmt};
            if (shAmt == '0) begin
              state_d  = DONE;
              result_d = bus.A;
              flags_d  = {bus.A[msb], (bus.A == '0), 2'b00};
            end else begin
              state_d = BUSY;
            end
          end else if (startMul) begin
            work_d  = bus.B;
            count_d = cntWidth'(data_width);
            state_d = BUSY;
          end else begin
            state_d  = DONE;
            result_d = aluRes;
            flags_d  = aluFlags;
          end
        end
      end
      BUSY: begin
        count_d = count_q - cntWidth'(1);
        if (mulActive) begin
          work_d  = mulLoNext;
          carry_d = mulHiNonZero;
        end else if (opSel_q == OP_SHL) begin
          work_d  = {work_q[msb-1:0], 1'b0};
          carry_d = work_q[msb];
        end else begin
          work_d  = {1'b0, work_q[msb:1]};
          carry_d = work_q[0];
        end
        if (count_q == cntWidth'(1)) begin
          state_d  = DONE;
          result_d = work_d;
          flags_d  = {work_d[msb], (work_d == '0), carry_d, 1'b0};
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  // Reset discards any in-flight work and clears the visible result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      flags_q  <= '0;
      work_q   <= '0;
      carry_q  <= 1'b0;
      count_q  <= '0;
      opSel_q  <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      flags_q  <= flags_d;
      work_q   <= work_d;
      carry_q  <= carry_d;
      count_q  <= count_d;
      opSel_q  <= opSel_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.R         = result_q;
  assign bus.flags     = flags_q;

endmodule

// File: doc/alu_hs.md
# alu_hs

Parametrised, handshaked successor to the single-cycle project ALU. Operands and opcode are accepted over a valid/ready input channel, and results are returned over a valid/ready output channel together with a 4-bit status flag vector. Shifts by a variable amount run iteratively. An iterative multiply is compiled in optionally. The block sits between the PS02 register-file/sequencer and the write-back path, and stalls the sequencer via `in_ready` while busy.

## Interface
- `data_width`, 32, operand/result width in bits (≥ 4)
- `sh_width`, `$clog2(data_width)`, shift-amount width (derived; do not override)
- `clk`  input  1  rising-edge clock
- `rst`  input  1  reset, synchronous, active-high
- `A`  input  `data_width`  operand A, sampled on accept
- `B`  input  `data_width`  operand B, sampled on accept
- `op`  input  4  opcode, sampled on accept
- `in_valid`  input  1  operand/opcode valid
- `in_ready`  output  1  block can accept; accept = `in_valid & in_ready`
- `R`  output  `data_width`  result, registered
- `flags`  output  4  {N, Z, C, V}, registered
- `out_valid`  output  1  `R`/`flags` valid
- `out_ready`  input  1  consumer takes result; handshake = `out_valid & out_ready`

## Operation
- **States:** IDLE, BUSY, DONE. `in_ready` = (state == IDLE). `out_valid` = (state == DONE).
- **IDLE, on accept:** latch A, B, op.
  - Single-cycle ops: go to DONE.
  - Shift ops: load a counter with `B[sh_width-1:0]`, go to BUSY. If the count is 0, go directly to DONE with R = A.
- **BUSY:** shift a working register by 1 bit per cycle and decrement the counter. At count 0, go to DONE.
- **DONE:** hold R and flags stable until `out_ready`, then go to IDLE. New input is not accepted in DONE.
- **Opcodes** (all arithmetic modulo 2^`data_width`):
  - 0: A−B
  - 1: A+B
  - 2: ~(A&B)
  - 3: A&B
  - 4: A|B
  - 5: ~(A|B)
  - 6: A^B
  - 7: ~A
  - 8: ~B
  - 9: B+1
  - a: A+1
  - b: A−1
  - c: B−1
  - d: A << `B[sh_width-1:0]` (logical, zero fill)
  - e: A >> `B[sh_width-1:0]` (logical, zero fill)
  - f: see Configuration
- **Flags:**
  - N = R[msb]; Z = (R == 0).
  - C:
    - add/inc: carry out of the msb.
    - sub/dec: borrow, i.e. 1 when the minuend is less than the subtrahend (unsigned).
    - shifts: last bit shifted out; 0 when the shift amount is 0.
    - logic ops: 0.
  - V: signed two's-complement overflow for ops 0, 1, 9, a, b, c; 0 for all other ops.
- **Reset** (`rst` high at a clock edge), from any state including mid-shift or mid-multiply:
  - state = IDLE; R = 0; flags = 0; counter = 0.
  - Any in-flight operation is discarded with no output.
  - `out_valid` = 0 and `in_ready` = 1 from the first edge after `rst` is sampled high.
- `in_valid` in BUSY or DONE is ignored. The source must hold its inputs until accepted.

## Timing
- Accept at edge t. Single-cycle op: `out_valid` = 1 after edge t+1.
- Shift by n: `out_valid` = 1 after edge t+1+n (n = 0 gives t+1).
- Multiply: `out_valid` = 1 after edge t+1+`data_width`.
- Handshake at edge u: `in_ready` = 1 after edge u+1. Peak throughput is one op per 2 cycles.
- `R` and `flags` change only on the edge entering DONE, or on reset.

## Configuration
- **`ALU_MUL_EN` defined:**
  - op f = unsigned A×B by shift-add, one partial product per BUSY cycle, `data_width` cycles.
  - R = low `data_width` bits; C = 1 if any high-half bit is nonzero; V = 0.
- **`ALU_MUL_EN` undefined:**
  - op f is single-cycle, R = 0, flags = {0,1,0,0}.
  - No multiplier datapath is synthesised.

## Test plan
- **Reset mid-shift:** `data_width` = 32, op d, A = 1, B = 20; assert `rst` 5 cycles after accept → no `out_valid`, R = 0, flags = 0, `in_ready` = 1 after the next edge.
- **Signed overflow:** op 1, A = 0x7FFFFFFF, B = 1 → R = 0x80000000, flags = {N=1, Z=0, C=0, V=1}, `out_valid` at accept+1.
- **Borrow:** op 0, A = 3, B = 5 → R = 0xFFFFFFFE, flags = {1, 0, 1, 0}.
- **Right shift with stall:** op e, A = 0x80000001, B = 7, `out_ready` low for 3 cycles after `out_valid` → `out_valid` at accept+8, R = 0x01000000, C = 0, R held stable until `out_ready`.
- **Zero-amount shift:** op d, A = 0xA5, B = 0x20 (amount field 0) → R = 0xA5, C = 0, latency 1.
- **Op f:** A = 0x10000, B = 0x10000.
  - With `ALU_MUL_EN`: R = 0, Z = 1, C = 1, latency 33.
  - Without it: R = 0, flags = {0,1,0,0}, latency 1.
